// File: rtl/vga_reg_snapshot_ctrl.sv
// Per-frame snapshot of the CPU debug register port into a shadow read by the VGA debug screen.
// Define VGA_SNAP_DBLBUF_EN for a double-buffered shadow (front/back banks swapped per snapshot).
module vga_reg_snapshot_ctrl #(
   parameter int   NREGS     = 32,
   parameter int   AW        = 5,
   parameter int   DW        = 32,
   parameter logic VSYNC_ACT = 1'b0
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          vsync,
   input  logic          snap_now,
   output logic          cpu_req,
   input  logic          cpu_gnt,
   output logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_data,
   input  logic [AW-1:0] vga_addr,
   output logic [DW-1:0] vga_data,
   output logic          busy,
   output logic          snap_done,
   output logic          overrun
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      CAPT,
      DONE
   } state_t;

   localparam int DEPTH = 2**AW;
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          vs_q, vs_d;
   logic          overrun_q, overrun_d;
   logic          trig;

`ifdef VGA_SNAP_DBLBUF_EN
   logic          front_q, front_d;
   logic [DW-1:0] mem_q [2][DEPTH];
   logic [DW-1:0] mem_d [2][DEPTH];
`else
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
`endif

   assign trig = ((vs_q != VSYNC_ACT) && (vsync == VSYNC_ACT)) || snap_now;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      vs_d      = vsync;
      overrun_d = overrun_q;
      mem_d     = mem_q;
      cpu_req   = 1'b0;
      snap_done = 1'b0;
`ifdef VGA_SNAP_DBLBUF_EN
      front_d   = front_q;
`endif
      // DONE still counts as busy, so a trigger there is an overrun too
      if (trig && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end
      unique case (state_q)
         IDLE: begin
            if (trig) begin
               state_d = REQ;
               idx_d   = '0;
            end
         end
         REQ: begin
            cpu_req = 1'b1;
            if (cpu_gnt) begin
               state_d = CAPT;
            end
         end
         CAPT: begin
`ifdef VGA_SNAP_DBLBUF_EN
            mem_d[~front_q][idx_q] = cpu_data;
`else
            mem_d[idx_q] = cpu_data;
`endif
            if (idx_q == LAST) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = REQ;
            end
         end
         DONE: begin
            snap_done = 1'b1;
            state_d   = IDLE;
            idx_d     = '0;
`ifdef VGA_SNAP_DBLBUF_EN
            front_d   = ~front_q;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         vs_q      <= ~VSYNC_ACT;
         overrun_q <= 1'b0;
`ifdef VGA_SNAP_DBLBUF_EN
         front_q   <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_q[b][i] <= '0;
            end
         end
`else
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         vs_q      <= vs_d;
         overrun_q <= overrun_d;
         mem_q     <= mem_d;
`ifdef VGA_SNAP_DBLBUF_EN
         front_q   <= front_d;
`endif
      end
   end

   // entries at or above NREGS are never written and stay zero
`ifdef VGA_SNAP_DBLBUF_EN
   assign vga_data = mem_q[front_q][vga_addr];
`else
   assign vga_data = mem_q[vga_addr];
`endif

   assign cpu_addr = idx_q;
   assign busy     = (state_q != IDLE);
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_vga_reg_snapshot_ctrl.sv
// Directed self-checking bench for vga_reg_snapshot_ctrl.
// Covers both shadow builds via VGA_SNAP_DBLBUF_EN.
module tb_vga_reg_snapshot_ctrl;

   logic        clk;
   logic        resetn;
   logic        vsync;
   logic        snap_now;
   logic        cpu_req;
   logic        cpu_gnt;
   logic [4:0]  cpu_addr;
   logic [31:0] cpu_data;
   logic [4:0]  vga_addr;
   logic [31:0] vga_data;
   logic        busy;
   logic        snap_done;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   logic [31:0] pat_base = 32'hA5A5_0000;
   logic        pat_add  = 1'b1;

   vga_reg_snapshot_ctrl dut (
      .clk       (clk),
      .resetn    (resetn),
      .vsync     (vsync),
      .snap_now  (snap_now),
      .cpu_req   (cpu_req),
      .cpu_gnt   (cpu_gnt),
      .cpu_addr  (cpu_addr),
      .cpu_data  (cpu_data),
      .vga_addr  (vga_addr),
      .vga_data  (vga_data),
      .busy      (busy),
      .snap_done (snap_done),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CPU port model: data one cycle after an accepted address
   initial cpu_data = 32'h0;
   always @(posedge clk) begin
      if (cpu_req && cpu_gnt) begin
         cpu_data <= pat_base | (pat_add ? {27'b0, cpu_addr} : 32'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_snap(output int n, output int d);
      n = 0;
      d = 0;
      for (int i = 0; i < 300; i++) begin
         if (busy) n++;
         if (snap_done) d++;
         if (!busy) break;
         step();
      end
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      vsync    = 1'b1;
      snap_now = 1'b0;
      cpu_gnt  = 1'b1;
      vga_addr = 5'd0;
      #12;
      checks++;
      if ({cpu_req, busy, snap_done, overrun} !== 4'b0000) begin
         $display("FAIL reset_ctrl got %b want 0000",
                  {cpu_req, busy, snap_done, overrun});
         errors++;
      end
      checks++;
      if (cpu_addr !== 5'd0) begin
         $display("FAIL reset_addr got %0d want 0", cpu_addr);
         errors++;
      end
      vga_addr = 5'd31;
      #1;
      checks++;
      if (vga_data !== 32'h0) begin
         $display("FAIL reset_shadow got %h want 0", vga_data);
         errors++;
      end
      step();
      resetn = 1'b1;
      step();
      step();
   endtask

   task automatic test_basic();
      int n, d;
      pat_base = 32'hA5A5_0000;
      pat_add  = 1'b1;
      cpu_gnt  = 1'b1;
      vsync    = 1'b0;
      step();
      wait_snap(n, d);
      checks++;
      if (n != 65) begin
         $display("FAIL basic_len got %0d want 65", n);
         errors++;
      end
      checks++;
      if (d != 1) begin
         $display("FAIL basic_done got %0d want 1", d);
         errors++;
      end
      vga_addr = 5'd7;
      #1;
      checks++;
      if (vga_data !== 32'hA5A5_0007) begin
         $display("FAIL basic_r7 got %h want a5a50007", vga_data);
         errors++;
      end
      vga_addr = 5'd31;
      #1;
      checks++;
      if (vga_data !== 32'hA5A5_001F) begin
         $display("FAIL basic_r31 got %h want a5a5001f", vga_data);
         errors++;
      end
      checks++;
      if (overrun !== 1'b0) begin
         $display("FAIL basic_ovr got %b want 0", overrun);
         errors++;
      end
      vsync = 1'b1;
      step();
   endtask

   task automatic test_stall();
      int n, d;
      bit found;
      found    = 1'b0;
      pat_base = 32'h5A5A_0000;
      pat_add  = 1'b1;
      cpu_gnt  = 1'b1;
      vga_addr = 5'd3;
      snap_now = 1'b1;
      step();
      snap_now = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (cpu_req && cpu_addr == 5'd3) begin
            found = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!found) begin
         $display("FAIL stall_reach got idx %0d want 3", cpu_addr);
         errors++;
      end
      cpu_gnt = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (cpu_req !== 1'b1 || cpu_addr !== 5'd3) begin
            $display("FAIL stall_hold got req %b addr %0d want 1 3",
                     cpu_req, cpu_addr);
            errors++;
         end
         checks++;
         if (vga_data !== 32'hA5A5_0003) begin
            $display("FAIL stall_nowr got %h want a5a50003", vga_data);
            errors++;
         end
      end
      cpu_gnt = 1'b1;
      step();
      step();
      checks++;
      if (cpu_req !== 1'b1 || cpu_addr !== 5'd4) begin
         $display("FAIL stall_resume got req %b addr %0d want 1 4",
                  cpu_req, cpu_addr);
         errors++;
      end
      wait_snap(n, d);
      checks++;
      if (vga_data !== 32'h5A5A_0003) begin
         $display("FAIL stall_r3 got %h want 5a5a0003", vga_data);
         errors++;
      end
      checks++;
      if (d != 1) begin
         $display("FAIL stall_done got %0d want 1", d);
         errors++;
      end
   endtask

   task automatic test_simul();
      int n, d;
      vsync    = 1'b0;
      snap_now = 1'b1;
      step();
      snap_now = 1'b0;
      wait_snap(n, d);
      for (int i = 0; i < 20; i++) begin
         step();
         if (snap_done) d++;
         if (busy) n++;
      end
      checks++;
      if (n != 65 || d != 1) begin
         $display("FAIL simul_once got len %0d done %0d want 65 1", n, d);
         errors++;
      end
      checks++;
      if (overrun !== 1'b0) begin
         $display("FAIL simul_ovr got %b want 0", overrun);
         errors++;
      end
      vsync = 1'b1;
      step();
   endtask

   task automatic test_overrun();
      int n, d;
      n = 0;
      d = 0;
      vsync = 1'b0;
      step();
      for (int i = 0; i < 300; i++) begin
         if (busy) n++;
         if (snap_done) d++;
         if (!busy) break;
         if (n == 5) vsync = 1'b1;
         if (n == 20) vsync = 1'b0;
         step();
      end
      checks++;
      if (n != 65) begin
         $display("FAIL ovr_len got %0d want 65", n);
         errors++;
      end
      checks++;
      if (overrun !== 1'b1) begin
         $display("FAIL ovr_flag got %b want 1", overrun);
         errors++;
      end
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (busy) n++;
         if (snap_done) d++;
      end
      checks++;
      if (n != 0 || d != 1) begin
         $display("FAIL ovr_nosecond got busy %0d done %0d want 0 1", n, d);
         errors++;
      end
      vsync = 1'b1;
      step();
   endtask

   task automatic test_abort();
      bit found;
      found    = 1'b0;
      cpu_gnt  = 1'b1;
      snap_now = 1'b1;
      step();
      snap_now = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (cpu_req && cpu_addr == 5'd15) begin
            found = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!found) begin
         $display("FAIL abort_reach got idx %0d want 15", cpu_addr);
         errors++;
      end
      resetn = 1'b0;
      #1;
      checks++;
      if (cpu_req !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL abort_async got req %b busy %b want 0 0",
                  cpu_req, busy);
         errors++;
      end
      checks++;
      if (overrun !== 1'b0) begin
         $display("FAIL abort_ovr got %b want 0", overrun);
         errors++;
      end
      for (int a = 0; a < 32; a += 7) begin
         vga_addr = 5'(a);
         #0.5;
         checks++;
         if (vga_data !== 32'h0) begin
            $display("FAIL abort_clr[%0d] got %h want 0", a, vga_data);
            errors++;
         end
      end
      step();
      resetn = 1'b1;
      step();
   endtask

   task automatic test_bank();
      int n, d;
      bit seen;
      pat_base = 32'h1;
      pat_add  = 1'b0;
      cpu_gnt  = 1'b1;
      snap_now = 1'b1;
      step();
      snap_now = 1'b0;
      wait_snap(n, d);
      vga_addr = 5'd31;
      #1;
      checks++;
      if (vga_data !== 32'h1) begin
         $display("FAIL bank_first got %h want 1", vga_data);
         errors++;
      end
      pat_base = 32'h2;
`ifdef VGA_SNAP_DBLBUF_EN
      seen     = 1'b0;
      snap_now = 1'b1;
      step();
      snap_now = 1'b0;
      for (int i = 0; i < 200; i++) begin
         checks++;
         if (vga_data !== 32'h1) begin
            $display("FAIL bank_front got %h want 1 at cyc %0d", vga_data, i);
            errors++;
         end
         if (snap_done) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      step();
      checks++;
      if (!seen || vga_data !== 32'h2) begin
         $display("FAIL bank_swap got done %b data %h want 1 2",
                  seen, vga_data);
         errors++;
      end
`else
      seen     = 1'b1;
      vga_addr = 5'd0;
      snap_now = 1'b1;
      step();
      snap_now = 1'b0;
      checks++;
      if (vga_data !== 32'h1) begin
         $display("FAIL bank_req got %h want 1", vga_data);
         errors++;
      end
      step();
      checks++;
      if (vga_data !== 32'h1) begin
         $display("FAIL bank_capt got %h want 1", vga_data);
         errors++;
      end
      step();
      checks++;
      if (seen && vga_data !== 32'h2) begin
         $display("FAIL bank_after got %h want 2", vga_data);
         errors++;
      end
      vga_addr = 5'd31;
      #1;
      checks++;
      if (vga_data !== 32'h1) begin
         $display("FAIL bank_partial got %h want 1", vga_data);
         errors++;
      end
`endif
      wait_snap(n, d);
      vga_addr = 5'd31;
      #1;
      checks++;
      if (vga_data !== 32'h2) begin
         $display("FAIL bank_final got %h want 2", vga_data);
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_simul();
      test_overrun();
      test_abort();
      test_bank();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
